// File: rtl/frog_input_pkg.sv
// Shared types and defaults for the frog direction-key conditioner.
// Bit positions of every per-direction vector follow dir_t (bit 0 = U).
package frog_input_pkg;

    typedef enum logic {READY, COOL} arb_state_t;

    typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

    localparam int NUM_DIRS            = 4;
    localparam int DEF_DB_CYCLES       = 8;
    localparam int DEF_COOLDOWN_CYCLES = 4;

    // Lowest dir_t index wins, giving U > D > L > R.
    function automatic logic [NUM_DIRS-1:0] pick_winner(input logic [NUM_DIRS-1:0] press);
        logic [NUM_DIRS-1:0] one_hot;
        one_hot = '0;
        if (press[DIR_U])      one_hot[DIR_U] = 1'b1;
        else if (press[DIR_D]) one_hot[DIR_D] = 1'b1;
        else if (press[DIR_L]) one_hot[DIR_L] = 1'b1;
        else if (press[DIR_R]) one_hot[DIR_R] = 1'b1;
        return one_hot;
    endfunction

endpackage

// File: rtl/frog_key_debounce.sv
// One raw key: two-flop synchronizer, run-length debounce, rising-edge press.
// press is high for one cycle on each debounced press; releases are silent.
module frog_key_debounce
    import frog_input_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic       sync1_reg;
    logic       s_reg;
    logic       db_reg;
    logic       db_q_reg;
    logic [7:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
            db_reg    <= 1'b0;
            db_q_reg  <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            sync1_reg <= key;
            s_reg     <= sync1_reg;
            db_q_reg  <= db_reg;
            // Any cycle agreeing with db restarts the disagreement run.
            if (s_reg == db_reg) begin
                cnt_reg <= 8'd0;
            end else if (cnt_reg == CNT_LAST) begin
                db_reg  <= s_reg;
                cnt_reg <= 8'd0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign press = db_reg & ~db_q_reg;

endmodule

// File: rtl/frog_key_conditioner.sv
// Four debounced direction keys feeding a priority arbiter with hop cooldown;
// emits at most one registered single-cycle move pulse per cycle.
module frog_key_conditioner
    import frog_input_pkg::*;
#(
    parameter int DB_CYCLES       = DEF_DB_CYCLES,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic keyL,
    input  logic keyR,
    input  logic keyU,
    input  logic keyD,
    input  logic freeze,
    output logic L,
    output logic R,
    output logic U,
    output logic D
);

    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_CYCLES - 1);

    logic [NUM_DIRS-1:0] keys;
    logic [NUM_DIRS-1:0] press;

    assign keys = {keyR, keyL, keyD, keyU};

    generate
        for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_key
            frog_key_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_db (
                .clk  (clk),
                .reset(reset),
                .key  (keys[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    arb_state_t          state_reg, state_next;
    logic [7:0]          cool_cnt_reg, cool_cnt_next;
    logic [NUM_DIRS-1:0] pulse_reg, pulse_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= READY;
            cool_cnt_reg <= 8'd0;
            pulse_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cool_cnt_reg <= cool_cnt_next;
            pulse_reg    <= pulse_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cool_cnt_next = cool_cnt_reg;
        pulse_next    = '0;
        // freeze discards presses outright and leaves the arbiter ready.
        if (freeze) begin
            state_next    = READY;
            cool_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                READY: begin
                    if (|press) begin
                        pulse_next    = pick_winner(press);
                        state_next    = COOL;
                        cool_cnt_next = 8'd0;
                    end
                end
                COOL: begin
                    if (cool_cnt_reg == COOL_LAST) begin
                        state_next    = READY;
                        cool_cnt_next = 8'd0;
                    end else begin
                        cool_cnt_next = cool_cnt_reg + 8'd1;
                    end
                end
            endcase
        end
    end

    assign {R, L, D, U} = pulse_reg;

endmodule

// File: tb/tb_frog_key_conditioner.sv
// Scoreboard bench: a window-based reference model predicts the pulse vector
// after every edge; a monitor pops and compares one edge later.
module tb_frog_key_conditioner;

    localparam int DB = 4;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic reset;
    logic keyL, keyR, keyU, keyD;
    logic freeze;
    logic L, R, U, D;

    always #5 clk = ~clk;

    frog_key_conditioner #(
        .DB_CYCLES      (DB),
        .COOLDOWN_CYCLES(CD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .keyL  (keyL),
        .keyR  (keyR),
        .keyU  (keyU),
        .keyD  (keyD),
        .freeze(freeze),
        .L     (L),
        .R     (R),
        .U     (U),
        .D     (D)
    );

    int checks = 0;
    int errors = 0;

    // Expected {R,L,D,U} after each edge.
    logic [3:0] exp_q[$];

    // Reference model: raw samples per key (bit j = sample j edges ago),
    // debounced level now and one edge earlier, and earliest accepting edge.
    logic [DB+1:0] hist[4];
    logic [3:0]    db_m;
    logic [3:0]    dbq_m;
    longint        edge_n   = 0;
    longint        ready_at = 0;

    task automatic model_step();
        logic [3:0]    raw;
        logic [3:0]    prs;
        logic [3:0]    outv;
        logic [DB-1:0] win;
        logic          found;
        raw  = {keyR, keyL, keyD, keyU};
        outv = '0;
        if (reset) begin
            for (int k = 0; k < 4; k++) hist[k] = '0;
            db_m     = '0;
            dbq_m    = '0;
            ready_at = edge_n + 1;
        end else begin
            prs   = db_m & ~dbq_m;
            dbq_m = db_m;
            for (int k = 0; k < 4; k++) begin
                hist[k] = {hist[k][DB:0], raw[k]};
                // db flips once the DB synchronized samples seen by this edge all disagree with it.
                win = hist[k][DB+1:2];
                if (db_m[k] ? (win == '0) : (&win)) db_m[k] = ~db_m[k];
            end
            if (freeze) begin
                ready_at = edge_n + 1;
            end else if (edge_n >= ready_at && prs != 4'b0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (prs[k] && !found) begin
                        outv[k] = 1'b1;
                        found   = 1'b1;
                    end
                end
                ready_at = edge_n + CD + 1;
            end
        end
        edge_n++;
        exp_q.push_back(outv);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) hist[k] = '0;
        db_m  = '0;
        dbq_m = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor
    initial begin
        int         mon_edge;
        logic [3:0] e;
        logic [3:0] got;
        mon_edge = 0;
        forever begin
            @(posedge clk);
            #1;
            got = {R, L, D, U};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty edge=%0d got RLDU=%b", mon_edge, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL pulses edge=%0d got RLDU=%b expected RLDU=%b", mon_edge, got, e);
                end
            end
            mon_edge++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got RLDU=%b expected RLDU=%b", name, got, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        keyL   = 1'b0;
        keyR   = 1'b0;
        keyU   = 1'b0;
        keyD   = 1'b0;
        freeze = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        $display("scenario clean press");
        keyL = 1'b1; tick(20); keyL = 1'b0; tick(12);

        $display("scenario bounce");
        keyU = 1'b1; tick(1); keyU = 1'b0; tick(1);
        keyU = 1'b1; tick(1); keyU = 1'b0; tick(10);
        keyU = 1'b1; tick(12); keyU = 1'b0; tick(12);

        $display("scenario simultaneous");
        keyL = 1'b1; keyU = 1'b1; tick(15);
        keyL = 1'b0; keyU = 1'b0; tick(12);

        $display("scenario cooldown");
        keyR = 1'b1; tick(2); keyD = 1'b1; tick(10);
        keyD = 1'b0; tick(8); keyD = 1'b1; tick(12);
        keyD = 1'b0; keyR = 1'b0; tick(12);

        $display("scenario freeze");
        freeze = 1'b1; keyD = 1'b1; tick(10);
        freeze = 1'b0; tick(10);
        keyD = 1'b0; tick(10);
        keyD = 1'b1; tick(12); keyD = 1'b0; tick(12);

        $display("scenario reset mid-debounce");
        keyL = 1'b1; tick(4);
        reset = 1'b1; #1;
        check_now("reset_midflight_outputs", {R, L, D, U}, 4'b0000);
        tick(2);
        reset = 1'b0; tick(15);
        keyL = 1'b0; tick(12);

        $display("scenario reset during pulse");
        keyR = 1'b1; tick(7);
        check_now("latency_pulse_r", {R, L, D, U}, 4'b1000);
        reset = 1'b1; #1;
        check_now("reset_clears_pulse", {R, L, D, U}, 4'b0000);
        tick(2);
        reset = 1'b0; tick(6);
        check_now("held_key_after_reset", {R, L, D, U}, 4'b0000);
        tick(1);
        check_now("held_key_refire", {R, L, D, U}, 4'b1000);
        keyR = 1'b0; tick(12);

        $display("scenario random");
        for (int i = 0; i < 3000; i++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 799) == 0) reset = 1'b1;
            if ($urandom_range(0, 9) == 0) keyL = ~keyL;
            if ($urandom_range(0, 9) == 0) keyR = ~keyR;
            if ($urandom_range(0, 9) == 0) keyU = ~keyU;
            if ($urandom_range(0, 9) == 0) keyD = ~keyD;
            if ($urandom_range(0, 39) == 0) freeze = ~freeze;
            tick(1);
        end
        reset  = 1'b0;
        freeze = 1'b0;
        keyL   = 1'b0;
        keyR   = 1'b0;
        keyU   = 1'b0;
        keyD   = 1'b0;
        tick(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_key_conditioner.md
# frog_key_conditioner

Converts the four raw direction keys (asynchronous, bouncy) into clean single-cycle move pulses for the per-cell frog light FSMs. Each key is synchronized, debounced and edge-detected. A small arbiter FSM then guarantees at most one direction pulse per cycle and enforces a hop cooldown. The L/R/U/D outputs fan out directly to every frog-light cell, so each cell sees exactly one pulse per physical press.

## Interface
- DB_CYCLES, 8: consecutive cycles a synchronized key must differ from its debounced value before the debounced value flips; legal values 2..255.
- COOLDOWN_CYCLES, 4: cycles after an emitted pulse during which new presses are dropped; legal values 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- keyL, keyR, keyU, keyD  in  1 each  raw direction keys, active-high, asynchronous to clk.
- freeze  in  1  suppresses all output pulses (game over, frog hit, level transition).
- L, R, U, D  out  1 each  registered move pulses, one cycle wide, at most one high per cycle.

## Operation
- Synchronizer, per key: two flops, both reset to 0. Call the second flop s.
- Debounce, per key: debounced value db resets to 0; counter cnt (8 bits) resets to 0.
  - If s == db: cnt <= 0.
  - If s != db and cnt == DB_CYCLES-1: db <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any single-cycle agreement with db restarts the count.
- Edge detect, per key: db_q is a registered copy of db (resets to 0). press = db & ~db_q. Releases produce no event. A held key yields exactly one press.
- Arbiter FSM, states READY and COOL. Reset state is READY, with cool_cnt = 0.
  - READY: if freeze = 0 and any press is high, register a one-hot pulse for the winner and go to COOL with cool_cnt <= 0.
  - Winner priority is U > D > L > R. Losing simultaneous presses are discarded, not queued.
  - COOL: all presses are dropped. cool_cnt increments each cycle. When cool_cnt == COOLDOWN_CYCLES-1, go to READY.
  - freeze = 1, in any state: next state is READY, cool_cnt <= 0, and all outputs are registered 0. Presses occurring while freeze is high are lost, not deferred.
- Outputs L/R/U/D reset to 0 and are cleared every cycle unless a pulse is being registered.

## Timing
- Reference point: raw key first sampled high at edge E0 and held stable.
  - db rises at E0+DB_CYCLES+1.
  - The output pulse is high from E0+DB_CYCLES+2 to E0+DB_CYCLES+3.
- After a pulse registered at edge Ep, the state is COOL until edge Ep+COOLDOWN_CYCLES, which makes it READY.
  - A press event in the cycle following that edge is accepted.
- Bounce: a raw glitch shorter than DB_CYCLES cycles, after synchronization, never changes db.
- Simultaneous presses on the same cycle: exactly one pulse, chosen by priority.
- Key held across cooldown expiry: no second pulse. The key must release (debounced) and press again.
- Reset asserted mid-operation: all flops clear asynchronously and outputs go to 0 immediately.
  - A key still held after reset deasserts is treated as a new press and fires after the normal latency.

## Structure
- Package frog_input_pkg holds:
  - typedef enum {READY, COOL} for the arbiter state;
  - typedef enum {DIR_U, DIR_D, DIR_L, DIR_R} for priority order;
  - default constants for DB_CYCLES and COOLDOWN_CYCLES.
- Sub-module frog_key_debounce, instantiated four times: synchronizer + debounce counter + edge detect, output press.
- The top level holds the arbiter FSM, the cooldown counter and the output registers.

## Test plan
All scenarios use DB_CYCLES = 4 and COOLDOWN_CYCLES = 4.
- Clean press: keyL high at E0 and held for 20 cycles -> L high for exactly one cycle after E6; R/U/D stay 0; no further pulse while held.
- Bounce: keyU toggled 1,0,1,0 on consecutive cycles, then low -> no pulse on any output. Then keyU held -> U pulse 6 cycles after the hold starts.
- Simultaneous: keyL and keyU rise on the same edge and are held -> exactly one pulse, on U; L never pulses.
- Cooldown: keyR pulse at Ep. keyD pressed so that its press event falls at Ep+2 -> no D pulse. Release keyD and re-press so that its event lands at or after Ep+4 -> D pulse emitted.
- Freeze: freeze high while keyD's press event occurs -> no pulse, even after freeze drops with the key still held. Release and re-press -> D pulses normally.
- Reset mid-flight: assert reset while the keyL debounce count is 2 -> L = 0 and all counters = 0 immediately. Deassert with keyL held -> L pulse after the full latency from restart.
